// File: rtl/polylut_pipe_ctrl.sv
// Stage-enable/occupancy controller and output result FIFO for the registered PolyLUT-Add pipeline.
// Define POLYLUT_CTRL_PERF_EN to include the accept/stall performance counters.
module polylut_pipe_ctrl #(
  parameter int STAGES = 10,
  parameter int DATA_W = 25,
  parameter int DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [STAGES-1:0]                    stage_en,
  input  logic [DATA_W-1:0]                    res_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_W-1:0]                    out_data,
  output logic [$clog2(STAGES+DEPTH+1)-1:0]    inflight,
  output logic [31:0]                          cnt_accept,
  output logic [31:0]                          cnt_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(STAGES+DEPTH+1);

  logic [STAGES-1:0] occ;
  logic [STAGES-1:0] en;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_nxt;
  logic              push;
  logic              pop;
  logic              accept;
  logic              chain;

  assign pop       = out_valid & out_ready;
  assign push      = occ[STAGES-1] & ((fifo_count < CW'(DEPTH)) | pop);
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);
  assign accept    = in_valid & en[0];
  assign stage_en  = en;
  assign in_ready  = en[0];
  assign out_data  = mem[rd_ptr];

  // Enables ripple from the output end: a stage may load if it is empty or its successor is taking its sample.
  always_comb begin
    en    = '0;
    chain = push;
    for (int i = STAGES-1; i >= 0; i--) begin
      en[i] = ~occ[i] | chain;
      chain = en[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
    end else begin
      if (en[0]) occ[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) occ[i] <= occ[i-1];
      end
    end
  end

  // Storage is cleared on reset so the head reads zero while the FIFO is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      inflight   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_nxt;
      out_valid  <= (count_nxt != '0);
      inflight   <= inflight + IW'(accept) - IW'(pop);
    end
  end

`ifdef POLYLUT_CTRL_PERF_EN
  logic [31:0] acc_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (accept) acc_q <= acc_q + 32'd1;
      if (in_valid & ~en[0]) stall_q <= stall_q + 32'd1;
    end
  end

  assign cnt_accept = acc_q;
  assign cnt_stall  = stall_q;
`else
  assign cnt_accept = '0;
  assign cnt_stall  = '0;
`endif

endmodule

// File: tb/tb_polylut_pipe_ctrl.sv
// Directed scoreboard bench for polylut_pipe_ctrl; models the stage-gated datapath and checks order, latency and flow control.
module tb_polylut_pipe_ctrl;

  localparam int STAGES = 10;
  localparam int DATA_W = 25;
  localparam int DEPTH  = 4;
  localparam int IW     = $clog2(STAGES+DEPTH+1);
`ifdef POLYLUT_CTRL_PERF_EN
  localparam int EXP_ACC   = 14;
  localparam int EXP_STALL = 6;
`else
  localparam int EXP_ACC   = 0;
  localparam int EXP_STALL = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic [STAGES-1:0] stage_en;
  logic [DATA_W-1:0] res_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IW-1:0]     inflight;
  logic [31:0]       cnt_accept;
  logic [31:0]       cnt_stall;

  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] dreg [STAGES];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] tag_next = 25'h01A0000;
  logic              obs_ready;
  logic              obs_valid;
  int                checks = 0;
  int                failures = 0;
  int                n_acc = 0;

  polylut_pipe_ctrl #(.STAGES(STAGES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stage_en(stage_en),
    .res_data(res_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight), .cnt_accept(cnt_accept), .cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: stage registers gated by stage_en, bubbles carry a marker that must never surface.
  always @(posedge clk) begin
    if (stage_en[0]) dreg[0] <= in_valid ? in_data : 25'h1FFFFFF;
    for (int i = 1; i < STAGES; i++) begin
      if (stage_en[i]) dreg[i] <= dreg[i-1];
    end
  end
  assign res_data = dreg[STAGES-1];

  task automatic check1(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [DATA_W-1:0] e;
    check1("sb_pop_nonempty", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check1("sb_out_data", 64'(out_data), 64'(e));
    end
  endtask

  // One cycle: drive at the falling edge, observe 1 ns later, then book-keep accept/pop.
  task automatic applyStimulus(input logic v, input logic r);
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    in_data   = tag_next;
    #1;
    obs_ready = in_ready;
    obs_valid = out_valid;
    check1("inflight", 64'(inflight), 64'(exp_q.size()));
    check1("in_ready_rule", 64'(in_ready), 64'(r | (exp_q.size() < STAGES+DEPTH)));
    if (out_valid && r) checkOutput();
    if (v && in_ready) begin
      exp_q.push_back(in_data);
      tag_next = tag_next + 25'd1;
      n_acc++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check1("rst_out_valid", 64'(out_valid), 64'd0);
    check1("rst_inflight", 64'(inflight), 64'd0);
    check1("rst_out_data", 64'(out_data), 64'd0);
    check1("rst_in_ready", 64'(in_ready), 64'd1);
    check1("rst_stage_en", 64'(stage_en), 64'({STAGES{1'b1}}));
    check1("rst_cnt_accept", 64'(cnt_accept), 64'd0);
    check1("rst_cnt_stall", 64'(cnt_stall), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check1("rst_hold_inflight", 64'(inflight), 64'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) applyStimulus(1'b0, 1'b1);
    check1("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();

    $display("[TB] single sample latency");
    for (int c = 0; c < 15; c++) begin
      applyStimulus(c == 0, 1'b1);
      check1("t1_out_valid", 64'(obs_valid), 64'(c == 11));
    end

    $display("[TB] 20 back-to-back samples");
    for (int c = 0; c < 35; c++) begin
      applyStimulus(c < 20, 1'b1);
      check1("t2_out_valid", 64'(obs_valid), 64'(c >= 11 && c <= 30));
      if (c < 20) check1("t2_in_ready", 64'(obs_ready), 64'd1);
    end
    check1("t2_all_out", 64'(exp_q.size()), 64'd0);

    $display("[TB] full stall");
    doReset();
    n_acc = 0;
    for (int c = 0; c < 20; c++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    check1("t3_accepted", 64'(n_acc), 64'd14);
    check1("t3_inflight", 64'(inflight), 64'd14);
    check1("t3_in_ready", 64'(obs_ready), 64'd0);
    check1("t3_cnt_accept", 64'(cnt_accept), 64'(EXP_ACC));
    check1("t3_cnt_stall", 64'(cnt_stall), 64'(EXP_STALL));
    drain();

    $display("[TB] alternating valid with held output");
    for (int c = 0; c < 20; c++) begin
      applyStimulus((c % 2) == 0, 1'b0);
      check1("t4_in_ready", 64'(obs_ready), 64'd1);
    end
    for (int c = 0; c < 20; c++) applyStimulus((c % 2) == 0, 1'b1);
    drain();

    $display("[TB] reset mid-operation");
    for (int c = 0; c < 14; c++) applyStimulus(c < 6, 1'b0);
    check1("t5_pre_out_valid", 64'(obs_valid), 64'd1);
    doReset();
    for (int c = 0; c < 15; c++) begin
      applyStimulus(c == 0, 1'b1);
      check1("t5_out_valid", 64'(obs_valid), 64'(c == 11));
    end
    check1("t5_all_out", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
